mlblock_res_drain: RTL and testbench
====================================

// Module: mlblock_res_drain
// PURPOSE
// - Downstream of the MLBlock tile: captures one PORT_RES_SIZE-wide result frame (Res_out) per
//   res_valid strobe and buffers frames in a small frame FIFO.
// - Serializes each frame lane-by-lane, lane 0 first, onto a valid/ready stream toward the
//   writeback / output memory path.
// - Decouples tile result timing from output back-pressure; flags dropped frames.
// PARAMETERS
// - RES_W          32  width of one result lane from the tile
// - PORT_RES_SIZE  4   lanes per frame (matches tile Res_out)
// - OUT_W          16  streamed word width; OUT_W <= RES_W
// - FIFO_DEPTH     4   frames buffered; power of 2, >= 2
// PORTS
// - clk         in   1                    clock, rising edge
// - reset       in   1                    asynchronous, active-low reset
// - res_in      in   PORT_RES_SIZE*RES_W  tile Res_out; lane k = res_in[(k+1)*RES_W-1:k*RES_W]
// - res_valid   in   1                    frame strobe: capture res_in this cycle
// - res_accept  out  1                    = !full; a frame offered now will be stored
// - m_data      out  OUT_W                current streamed word
// - m_valid     out  1                    m_data valid
// - m_ready     in   1                    consumer ready
// - m_last      out  1                    high with lane PORT_RES_SIZE-1 of a frame
// - frame_cnt   out  $clog2(FIFO_DEPTH)+1 frames held, including the one being streamed
// - overflow    out  1                    sticky: a frame was dropped
// - sat_flag    out  1                    sticky: a word saturated (macro only; else 0)
// - clr_flags   in   1                    sync clear of overflow/sat_flag
// BEHAVIOUR
// - Reset (async assert, sync deassert by user): wr_ptr = rd_ptr = 0, lane_idx = 0, frame_cnt = 0,
//   overflow = sat_flag = 0. Outputs take these values immediately: m_valid = 0, m_last = 0,
//   res_accept = 1, m_data = 0.
// - Reset mid-stream discards all buffered frames and any partially streamed frame; no resume.
// - Storage: FIFO_DEPTH x PORT_RES_SIZE*RES_W register array; pointers wrap modulo FIFO_DEPTH.
// - full = (frame_cnt == FIFO_DEPTH).
// - Push: res_valid && !full -> write res_in at wr_ptr at the clock edge; wr_ptr++.
// - Drop: res_valid && full -> frame discarded, overflow <= 1. This holds even if a pop occurs
//   in the same cycle, so res_accept alone predicts acceptance.
// - Stream outputs:
//   - m_valid = (frame_cnt != 0).
//   - m_data = lane lane_idx of frame rd_ptr, combinational from the array.
//   - m_last = m_valid && (lane_idx == PORT_RES_SIZE-1).
// - Latency: a frame pushed at edge N into an empty FIFO is presented with m_valid = 1 in the
//   cycle after edge N.
// - Handshake: transfer when m_valid && m_ready.
//   - Non-last lane: lane_idx++.
//   - Last lane: lane_idx <= 0, rd_ptr++ (pop).
//   - When m_ready = 0, m_data, m_last and lane_idx are held stable while m_valid = 1.
// - frame_cnt next = frame_cnt + push - pop; simultaneous push and pop leaves it unchanged.
// - Empty: m_valid = 0; m_ready is ignored.
// - Full: res_accept = 0 until the cycle after the pop edge.
// - Sticky flags:
//   - clr_flags clears overflow/sat_flag at the edge.
//   - A set event in the same cycle wins: the flag stays 1.
// - Lane data are two's-complement signed throughout.
// CONFIGURATION
// - Macro MLBLOCK_RES_DRAIN_SAT_EN:
//   - Defined: m_data = signed saturation of the RES_W lane to OUT_W, i.e. clamped to
//     [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat_flag <= 1 on any transferred word that clamped.
//   - Undefined: m_data = lane[OUT_W-1:0] (truncation), no saturation logic, sat_flag tied 0.
//   - If OUT_W == RES_W the word passes through unchanged in both cases.
// TESTING
// - Single frame: push lanes {1,2,3,4}, m_ready=1
//   -> m_data 1,2,3,4 on 4 consecutive cycles starting 1 cycle after the push; m_last only on 4;
//   frame_cnt 1 -> 0.
// - Back-pressure: push 2 frames {A0..A3},{B0..B3}; toggle m_ready 1,0,1,0...
//   -> order A0..A3,B0..B3, no duplicates or skips, data stable while stalled.
// - Overflow: m_ready=0, push 5 frames with FIFO_DEPTH=4
//   -> res_accept 0 after the 4th; 5th dropped, overflow=1. Then clr_flags -> overflow=0.
//   Drain yields frames 1-4 only.
// - Full + simultaneous pop/push: FIFO full, streaming last lane with m_ready=1, res_valid=1
//   -> frame dropped, overflow=1, frame_cnt 4 -> 3.
// - Saturation (macro on, RES_W=32, OUT_W=16): lanes {40000,-40000,100,-1}
//   -> m_data 32767,-32768,100,-1; sat_flag=1.
//   Macro off -> m_data = low 16 bits (0x9C40, 0x63C0, 100, 0xFFFF); sat_flag=0.
// - Reset mid-stream: assert reset after lane 1 of 3 buffered frames
//   -> m_valid=0 immediately, frame_cnt=0. After release, a new frame streams from lane 0.

Source files
------------

// File: rtl/mlblock_res_drain.sv
// Result-frame drain: buffers whole tile result frames and streams them lane by lane.
// Optional signed saturation of each lane to OUT_W is enabled by MLBLOCK_RES_DRAIN_SAT_EN.
module mlblock_res_drain #(
  parameter int RES_W         = 32,
  parameter int PORT_RES_SIZE = 4,
  parameter int OUT_W         = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PORT_RES_SIZE*RES_W-1:0] res_in,
  input  logic                           res_valid,
  output logic                           res_accept,
  output logic [OUT_W-1:0]               m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic [$clog2(FIFO_DEPTH):0]    frame_cnt,
  output logic                           overflow,
  output logic                           sat_flag,
  input  logic                           clr_flags
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = (PORT_RES_SIZE > 1) ? $clog2(PORT_RES_SIZE) : 1;
  localparam int FW = PORT_RES_SIZE * RES_W;
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(PORT_RES_SIZE - 1);

  logic [FW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    lane_idx;
  logic [RES_W-1:0] lane;
  logic [OUT_W-1:0] word;
  logic             full;
  logic             push;
  logic             drop;
  logic             xfer;
  logic             pop;

  // Stream handshake: a word moves when m_valid && m_ready at the rising edge;
  // while m_valid is high and m_ready low, m_data/m_last stay put.
  assign full       = (frame_cnt == DEPTH_C);
  assign res_accept = !full;
  assign push       = res_valid && !full;
  assign drop       = res_valid && full;
  assign m_valid    = (frame_cnt != '0);
  assign xfer       = m_valid && m_ready;
  assign pop        = xfer && (lane_idx == LAST_LANE);
  assign m_last     = m_valid && (lane_idx == LAST_LANE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lane_idx  <= '0;
      frame_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (xfer) begin
        if (pop) begin
          lane_idx <= '0;
          rd_ptr   <= rd_ptr + PW'(1);
        end else begin
          lane_idx <= lane_idx + LW'(1);
        end
      end
      case ({push, pop})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  // A full-cycle offer is dropped even if the head frame pops on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clr_flags) overflow <= 1'b0;
  end

  always_comb begin
    lane = '0;
    for (int k = 0; k < PORT_RES_SIZE; k++) begin
      if (lane_idx == LW'(k)) lane = mem[rd_ptr][k*RES_W +: RES_W];
    end
  end

`ifdef MLBLOCK_RES_DRAIN_SAT_EN
  localparam int HW = RES_W - OUT_W + 1;
  logic [HW-1:0] hi;
  logic          clamp;

  // In range exactly when every bit from the OUT_W sign position upward agrees.
  assign hi    = lane[RES_W-1:OUT_W-1];
  assign clamp = !((&hi) || !(|hi));

  always_comb begin
    word = lane[OUT_W-1:0];
    if (clamp) word = lane[RES_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              sat_flag <= 1'b0;
    else if (xfer && clamp)  sat_flag <= 1'b1;
    else if (clr_flags)      sat_flag <= 1'b0;
  end
`else
  logic unused_lane;
  assign unused_lane = ^lane;
  assign word        = lane[OUT_W-1:0];
  assign sat_flag    = 1'b0;
`endif

  assign m_data = m_valid ? word : '0;

endmodule

// File: tb/tb_mlblock_res_drain.sv
// Directed bench for mlblock_res_drain: vector table for push/stream/overflow plus hand sequences.
module tb_mlblock_res_drain;

  localparam int RES_W = 32;
  localparam int PRS   = 4;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic                 clk;
  logic                 reset;
  logic [PRS*RES_W-1:0] res_in;
  logic                 res_valid;
  logic                 res_accept;
  logic [OUT_W-1:0]     m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic [2:0]           frame_cnt;
  logic                 overflow;
  logic                 sat_flag;
  logic                 clr_flags;

  int tests = 0;
  int fails = 0;

  mlblock_res_drain #(
    .RES_W(RES_W), .PORT_RES_SIZE(PRS), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .res_in(res_in), .res_valid(res_valid),
    .res_accept(res_accept), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_cnt(frame_cnt), .overflow(overflow), .sat_flag(sat_flag),
    .clr_flags(clr_flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] base;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_acc;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[29];
  logic [OUT_W-1:0] exp_q[$];

  function automatic logic [PRS*RES_W-1:0] mk(input logic [31:0] b);
    logic [PRS*RES_W-1:0] r;
    for (int k = 0; k < PRS; k++) r[k*RES_W +: RES_W] = b + 32'(k);
    return r;
  endfunction

  function automatic vec_t v(input logic rv, input logic [31:0] base, input logic rdy,
                             input logic clr, input logic ev, input logic [15:0] ed,
                             input logic el, input logic ea, input logic [2:0] ec,
                             input logic eo);
    vec_t t;
    t.rv = rv; t.base = base; t.rdy = rdy; t.clr = clr; t.e_valid = ev; t.e_data = ed;
    t.e_last = el; t.e_acc = ea; t.e_cnt = ec; t.e_ovf = eo;
    return t;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base);
    res_valid = 1'b1;
    res_in    = mk(base);
    tick();
    res_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    string n;
    res_valid = vecs[i].rv;
    res_in    = mk(vecs[i].base);
    m_ready   = vecs[i].rdy;
    clr_flags = vecs[i].clr;
    #1;
    n = $sformatf("v%0d", i);
    check({n, ".m_valid"},    32'(m_valid),    32'(vecs[i].e_valid));
    check({n, ".m_data"},     32'(m_data),     32'(vecs[i].e_data));
    check({n, ".m_last"},     32'(m_last),     32'(vecs[i].e_last));
    check({n, ".res_accept"}, 32'(res_accept), 32'(vecs[i].e_acc));
    check({n, ".frame_cnt"},  32'(frame_cnt),  32'(vecs[i].e_cnt));
    check({n, ".overflow"},   32'(overflow),   32'(vecs[i].e_ovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [OUT_W-1:0] held;
    logic             stalled;
    int               got;
    logic [15:0]      exp_sat[4];
    logic             exp_sat_flag;

    // single frame {1,2,3,4}
    vecs[0] = v(1, 1, 1, 0, 0, 16'd0, 0, 1, 3'd0, 0);
    vecs[1] = v(0, 0, 1, 0, 1, 16'd1, 0, 1, 3'd1, 0);
    vecs[2] = v(0, 0, 1, 0, 1, 16'd2, 0, 1, 3'd1, 0);
    vecs[3] = v(0, 0, 1, 0, 1, 16'd3, 0, 1, 3'd1, 0);
    vecs[4] = v(0, 0, 1, 0, 1, 16'd4, 1, 1, 3'd1, 0);
    vecs[5] = v(0, 0, 1, 0, 0, 16'd0, 0, 1, 3'd0, 0);
    // overflow: five pushes while stalled, fifth dropped, then clear
    vecs[6]  = v(1, 16, 0, 0, 0, 16'd0,  0, 1, 3'd0, 0);
    vecs[7]  = v(1, 32, 0, 0, 1, 16'd16, 0, 1, 3'd1, 0);
    vecs[8]  = v(1, 48, 0, 0, 1, 16'd16, 0, 1, 3'd2, 0);
    vecs[9]  = v(1, 64, 0, 0, 1, 16'd16, 0, 1, 3'd3, 0);
    vecs[10] = v(1, 80, 0, 0, 1, 16'd16, 0, 0, 3'd4, 0);
    vecs[11] = v(0, 0,  0, 1, 1, 16'd16, 0, 0, 3'd4, 1);
    // drain: frames 16,32,48,64 only
    for (int f = 0; f < 4; f++)
      for (int l = 0; l < 4; l++)
        vecs[12 + f*4 + l] = v(0, 0, 1, 0, 1, 16'(16*(f+1) + l), (l == 3),
                               (f != 0), 3'(4 - f), 0);
    vecs[28] = v(0, 0, 1, 0, 0, 16'd0, 0, 1, 3'd0, 0);

    reset = 1'b0; res_valid = 1'b0; res_in = '0; m_ready = 1'b0; clr_flags = 1'b0;
    #2;
    check("rst.m_valid",    32'(m_valid),    32'd0);
    check("rst.m_last",     32'(m_last),     32'd0);
    check("rst.res_accept", 32'(res_accept), 32'd1);
    check("rst.m_data",     32'(m_data),     32'd0);
    check("rst.frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst.overflow",   32'(overflow),   32'd0);
    check("rst.sat_flag",   32'(sat_flag),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 29; i++) run_vec(i);

    // back-pressure: A and B frames, m_ready toggling
    m_ready = 1'b0;
    push_frame(32'hA0);
    push_frame(32'hB0);
    for (int k = 0; k < 4; k++) exp_q.push_back(OUT_W'(32'hA0 + k));
    for (int k = 0; k < 4; k++) exp_q.push_back(OUT_W'(32'hB0 + k));
    stalled = 1'b0; held = '0; got = 0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      m_ready = (c % 2 == 0);
      #1;
      if (stalled) check("bp.held_data", 32'(m_data), 32'(held));
      if (m_valid && m_ready) begin
        check("bp.data", 32'(m_data), 32'(exp_q.pop_front()));
        check("bp.last", 32'(m_last), 32'(got % 4 == 3));
        got++;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      @(posedge clk);
      #1;
    end
    check("bp.remaining", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b0;
    #1;
    check("bp.empty", 32'(m_valid), 32'd0);

    // full plus pop and push on the same edge
    push_frame(32'h20); push_frame(32'h30); push_frame(32'h40); push_frame(32'h50);
    check("fp.cnt_full", 32'(frame_cnt), 32'd4);
    m_ready = 1'b1;
    tick(); tick(); tick();
    check("fp.last_lane", 32'(m_last),     32'd1);
    check("fp.accept0",   32'(res_accept), 32'd0);
    res_valid = 1'b1;
    res_in    = mk(32'h99);
    tick();
    res_valid = 1'b0;
    check("fp.overflow", 32'(overflow),   32'd1);
    check("fp.cnt",      32'(frame_cnt),  32'd3);
    check("fp.accept1",  32'(res_accept), 32'd1);
    check("fp.next",     32'(m_data),     32'h30);
    clr_flags = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    clr_flags = 1'b0;
    check("fp.drained",  32'(frame_cnt), 32'd0);
    check("fp.ovf_clr",  32'(overflow),  32'd0);

    // saturation / truncation of wide lanes
`ifdef MLBLOCK_RES_DRAIN_SAT_EN
    exp_sat[0] = 16'h7FFF; exp_sat[1] = 16'h8000; exp_sat[2] = 16'd100; exp_sat[3] = 16'hFFFF;
    exp_sat_flag = 1'b1;
`else
    exp_sat[0] = 16'h9C40; exp_sat[1] = 16'h63C0; exp_sat[2] = 16'd100; exp_sat[3] = 16'hFFFF;
    exp_sat_flag = 1'b0;
`endif
    m_ready   = 1'b1;
    res_valid = 1'b1;
    res_in    = {-32'sd1, 32'sd100, -32'sd40000, 32'sd40000};
    tick();
    res_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sat.lane%0d", k), 32'(m_data), 32'(exp_sat[k]));
      tick();
    end
    check("sat.flag", 32'(sat_flag), 32'(exp_sat_flag));
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("sat.flag_clr", 32'(sat_flag), 32'd0);

    // reset mid-stream
    m_ready = 1'b0;
    push_frame(32'h100); push_frame(32'h200); push_frame(32'h300);
    m_ready = 1'b1;
    tick(); tick();
    check("rm.lane2", 32'(m_data), 32'h102);
    #2;
    reset = 1'b0;
    #1;
    check("rm.m_valid",    32'(m_valid),    32'd0);
    check("rm.frame_cnt",  32'(frame_cnt),  32'd0);
    check("rm.m_data",     32'(m_data),     32'd0);
    check("rm.res_accept", 32'(res_accept), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    push_frame(32'h70);
    check("rm.new_lane0", 32'(m_data),    32'h70);
    check("rm.new_cnt",   32'(frame_cnt), 32'd1);
    tick();
    check("rm.new_lane1", 32'(m_data), 32'h71);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
